// File: rtl/vga_photo_pkg.sv
// Shared constants and scan-state encoding for the VGA photo reader.
// Active area, default sync offsets, default image size and ROM address width.
package vga_photo_pkg;

  localparam int H_ACTIVE   = 800;
  localparam int V_ACTIVE   = 600;
  localparam int H_OFS_DEF  = 88;
  localparam int V_OFS_DEF  = 23;
  localparam int X_SIZE_DEF = 128;
  localparam int Y_SIZE_DEF = 96;
  localparam int ROM_AW     = 14;

  typedef enum logic [1:0] {WAIT_FRAME, ABOVE, SCAN, BELOW} state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags its rising edge (previous 0, current 1).
module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_rise
);

  logic r_prev;

  // History resets high so a sync level already high at reset release is not an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_sync;
  end

  assign o_rise = ~r_prev & i_sync;

endmodule

// File: rtl/vga_photo_reader.sv
// Recovers the scan position from vga_driver's syncs and streams a windowed image from a sync ROM.
// Define VGA_PHOTO_BOUNCE_EN to make the window origin bounce diagonally one step per frame.
module vga_photo_reader
  import vga_photo_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF,
  parameter int H_OFS  = H_OFS_DEF,
  parameter int V_OFS  = V_OFS_DEF,
  parameter int ORG_X0 = 0,
  parameter int ORG_Y0 = 0
) (
  input  logic              CLK_40M,
  input  logic              RST,
  input  logic              HSYNC,
  input  logic              VSYNC,
  input  logic [7:0]        ROM_DATA,
  output logic [ROM_AW-1:0] ROM_ADDR,
  output logic [15:0]       VGA_X,
  output logic [15:0]       VGA_Y,
  output logic [7:0]        VGA_DATA,
  output logic              VGA_VALID
);

  localparam logic [ROM_AW-1:0] ADDR_MAX = ROM_AW'(X_SIZE * Y_SIZE - 1);
  localparam logic [ROM_AW-1:0] ADDR_ONE = ROM_AW'(1);

  logic              w_hRise, w_vRise;
  logic [10:0]       r_ccnt;
  logic [9:0]        r_lcnt, w_lcntNext;
  logic [15:0]       w_orgX, w_orgY;
  logic [15:0]       w_col, w_row, w_rowNext;
  logic              w_colOk, w_rowOk, w_rowNextOk, w_inWin;
  state_t            r_state, w_stateNext;
  logic [ROM_AW-1:0] r_addr;
  logic              r_v1;
  logic [15:0]       r_x1, r_y1;

  vga_sync_edge u_hEdge (.i_clk(CLK_40M), .i_rst(RST), .i_sync(HSYNC), .o_rise(w_hRise));
  vga_sync_edge u_vEdge (.i_clk(CLK_40M), .i_rst(RST), .i_sync(VSYNC), .o_rise(w_vRise));

  // A VSYNC rise wins over a coincident HSYNC rise, which then goes uncounted.
  always_comb begin
    w_lcntNext = r_lcnt;
    if (w_vRise)                             w_lcntNext = '0;
    else if (w_hRise && r_lcnt != 10'h3FF)   w_lcntNext = r_lcnt + 10'd1;
  end

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      r_ccnt <= '0;
      r_lcnt <= '0;
    end else begin
      r_lcnt <= w_lcntNext;
      if (w_hRise)                 r_ccnt <= '0;
      else if (r_ccnt != 11'h7FF)  r_ccnt <= r_ccnt + 11'd1;
    end
  end

`ifdef VGA_PHOTO_BOUNCE_EN
  logic [15:0] r_orgX, r_orgY;
  logic        r_dx, r_dy;
  logic        w_xUp, w_yUp;

  // Direction for this step: keep going unless sitting on the wall being approached.
  assign w_xUp = r_dx ? (r_orgX != 16'(H_ACTIVE - X_SIZE)) : (r_orgX == 16'd0);
  assign w_yUp = r_dy ? (r_orgY != 16'(V_ACTIVE - Y_SIZE)) : (r_orgY == 16'd0);

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      r_orgX <= 16'(ORG_X0);
      r_orgY <= 16'(ORG_Y0);
      r_dx   <= 1'b1;
      r_dy   <= 1'b1;
    end else if (w_vRise) begin
      r_orgX <= w_xUp ? r_orgX + 16'd1 : r_orgX - 16'd1;
      r_orgY <= w_yUp ? r_orgY + 16'd1 : r_orgY - 16'd1;
      r_dx   <= w_xUp;
      r_dy   <= w_yUp;
    end
  end

  assign w_orgX = r_orgX;
  assign w_orgY = r_orgY;
`else
  assign w_orgX = 16'(ORG_X0);
  assign w_orgY = 16'(ORG_Y0);
`endif

  assign w_colOk     = r_ccnt >= 11'(H_OFS);
  assign w_rowOk     = r_lcnt >= 10'(V_OFS);
  assign w_rowNextOk = w_lcntNext >= 10'(V_OFS);
  assign w_col       = 16'(r_ccnt) - 16'(H_OFS);
  assign w_row       = 16'(r_lcnt) - 16'(V_OFS);
  assign w_rowNext   = 16'(w_lcntNext) - 16'(V_OFS);

  assign w_inWin = (r_state == SCAN) && w_colOk && w_rowOk
                && (w_col >= w_orgX) && (w_col < w_orgX + 16'(X_SIZE))
                && (w_row >= w_orgY) && (w_row < w_orgY + 16'(Y_SIZE));

  always_ff @(posedge CLK_40M) begin
    if (RST) r_state <= WAIT_FRAME;
    else     r_state <= w_stateNext;
  end

  // Row transitions look at the line count this HSYNC rise is about to load.
  always_comb begin
    w_stateNext = r_state;
    if (w_vRise) begin
      w_stateNext = ABOVE;
    end else if (w_hRise && w_rowNextOk) begin
      case (r_state)
        ABOVE:   if (w_rowNext == w_orgY)                  w_stateNext = SCAN;
        SCAN:    if (w_rowNext == w_orgY + 16'(Y_SIZE))    w_stateNext = BELOW;
        default: ;
      endcase
    end
  end

  // ROM_ADDR is the live address counter, so ROM data lines up one clock later.
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      r_addr    <= '0;
      r_v1      <= 1'b0;
      r_x1      <= '0;
      r_y1      <= '0;
      VGA_VALID <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_DATA  <= '0;
    end else begin
      if (w_vRise)                             r_addr <= '0;
      else if (w_inWin && r_addr != ADDR_MAX)  r_addr <= r_addr + ADDR_ONE;
      r_v1 <= w_inWin;
      if (w_inWin) begin
        r_x1 <= w_col;
        r_y1 <= w_row;
      end
      VGA_VALID <= r_v1;
      if (r_v1) begin
        VGA_X    <= r_x1;
        VGA_Y    <= r_y1;
        VGA_DATA <= ROM_DATA;
      end
    end
  end

  assign ROM_ADDR = r_addr;

endmodule

// File: tb/tb_vga_photo_reader.sv
// Bench for vga_photo_reader: random sync timing and ROM contents, expected pixels derived
// from each line's position within the frame and the window origin.
module tb_vga_photo_reader;
  import vga_photo_pkg::*;

  localparam int XS   = 16;
  localparam int YS   = 6;
  localparam int HO   = 10;
  localparam int VO   = 3;
  localparam int OX0  = 5;
  localparam int OY0  = 2;
  localparam int NPIX = XS * YS;

  typedef struct {
    int cycle;
    int x;
    int y;
    int data;
  } expPix_t;

  logic              clk = 1'b0;
  logic              rst, hs, vs;
  logic [7:0]        romData = 8'h00;
  logic [ROM_AW-1:0] romAddr;
  logic [15:0]       vgaX, vgaY;
  logic [7:0]        vgaData;
  logic              vgaValid;
  logic [7:0]        rom [0:16383];

  expPix_t expQ[$];
  int      edgeCnt = 0;
  int      nCompared = 0;
  int      nMismatched = 0;
  int      frameValid = 0;
  int      orgX = OX0, orgY = OY0, dx = 1, dy = 1;
  bit      armed = 1'b0;
  int      lastX = 0, lastY = 0, lastD = 0;

  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddr];

  vga_photo_reader #(
    .X_SIZE(XS), .Y_SIZE(YS), .H_OFS(HO), .V_OFS(VO), .ORG_X0(OX0), .ORG_Y0(OY0)
  ) dut (
    .CLK_40M(clk), .RST(rst), .HSYNC(hs), .VSYNC(vs), .ROM_DATA(romData),
    .ROM_ADDR(romAddr), .VGA_X(vgaX), .VGA_Y(vgaY), .VGA_DATA(vgaData), .VGA_VALID(vgaValid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (edge %0d)", tag, obs, expv, edgeCnt);
    end
  endtask

  // Each edge either delivers the next expected pixel or must hold the last one.
  task automatic monitorOutputs();
    expPix_t e;
    if (vgaValid === 1'b1) frameValid++;
    if (expQ.size() > 0 && expQ[0].cycle == edgeCnt) begin
      e = expQ.pop_front();
      checkOutput("valid", 64'(vgaValid), 64'(1));
      checkOutput("pixX", 64'(vgaX), 64'(e.x));
      checkOutput("pixY", 64'(vgaY), 64'(e.y));
      checkOutput("pixData", 64'(vgaData), 64'(e.data));
      lastX = e.x;
      lastY = e.y;
      lastD = e.data;
    end else begin
      checkOutput("validIdle", 64'(vgaValid), 64'(0));
      checkOutput("holdXYD", 64'({vgaX, vgaY, vgaData}),
                  64'({lastX[15:0], lastY[15:0], lastD[7:0]}));
    end
  endtask

  task automatic applyStimulus(input logic h, input logic v, input logic r);
    hs  = h;
    vs  = v;
    rst = r;
    @(posedge clk);
    #1;
    edgeCnt++;
    monitorOutputs();
  endtask

  // Position c clocks after a line's HSYNC rise, on frame line 'row' relative to active line 0.
  task automatic expectPixel(input int c, input int row);
    expPix_t e;
    int col;
    col = c - HO;
    if (armed && row >= orgY && row < orgY + YS && col >= orgX && col < orgX + XS) begin
      e.cycle = edgeCnt + 1 + 2;
      e.x     = col;
      e.y     = row;
      e.data  = int'(rom[(row - orgY) * XS + (col - orgX)]);
      expQ.push_back(e);
    end
  endtask

  task automatic stepOrigin();
`ifdef VGA_PHOTO_BOUNCE_EN
    if (orgX + dx > H_ACTIVE - XS || orgX + dx < 0) dx = -dx;
    if (orgY + dy > V_ACTIVE - YS || orgY + dy < 0) dy = -dy;
    orgX += dx;
    orgY += dy;
`endif
  endtask

  // One frame: line 0 carries the VSYNC rise (with or without a coincident HSYNC rise),
  // the last line holds VSYNC low. Optionally pulses reset at (rstLine, rstCol).
  task automatic runFrame(input bit coincident, input int rstLine, input int rstCol);
    int nl, len, hLow, d;
    logic h, v, r;
    bit vRiseNow;
    nl = VO + orgY + YS + 1 + int'($urandom_range(1, 3));
    for (int j = 0; j < nl; j++) begin
      len  = HO + orgX + XS + 4 + int'($urandom_range(0, 12));
      hLow = int'($urandom_range(2, 5));
      d    = (j == 0 && !coincident) ? int'($urandom_range(1, 20)) : 0;
      for (int c = 0; c < len; c++) begin
        h = (c < len - hLow);
        v = (j != nl - 1) && !(j == 0 && c < d);
        r = 1'b0;
        vRiseNow = (j == 0 && c == d);
        if (vRiseNow) begin
          armed      = 1'b1;
          frameValid = 0;
          stepOrigin();
        end
        if (j == rstLine && c == rstCol) begin
          r = 1'b1;
          while (expQ.size() > 0 && expQ[expQ.size() - 1].cycle >= edgeCnt + 1)
            expQ.pop_back();
          armed = 1'b0;
          lastX = 0;
          lastY = 0;
          lastD = 0;
          orgX  = OX0;
          orgY  = OY0;
          dx    = 1;
          dy    = 1;
        end
        if (!r) expectPixel(c, j - VO);
        applyStimulus(h, v, r);
        if (vRiseNow) checkOutput("romAddrClr", 64'(romAddr), 64'(0));
        if (r) begin
          checkOutput("romAddrRst", 64'(romAddr), 64'(0));
          checkOutput("validRst", 64'(vgaValid), 64'(0));
        end
      end
    end
    if (armed) begin
      checkOutput("romAddrEnd", 64'(romAddr), 64'(NPIX - 1));
      checkOutput("validCount", 64'(frameValid), 64'(NPIX));
    end
  endtask

  initial begin
    int len, hLow;
    for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("romAddrRst", 64'(romAddr), 64'(0));

    // Syncs idle low, then a few HSYNC-only lines: nothing may be emitted before a VSYNC rise.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      len  = int'($urandom_range(30, 50));
      hLow = int'($urandom_range(2, 5));
      for (int c = 0; c < len; c++) applyStimulus(c < len - hLow, 1'b0, 1'b0);
    end
    checkOutput("romAddrIdle", 64'(romAddr), 64'(0));

    for (int f = 0; f < 10; f++) begin
      runFrame(bit'($urandom_range(0, 1)),
               (f == 4) ? VO + orgY + 3 : -1,
               HO + orgX + int'($urandom_range(0, XS - 1)));
    end

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pendingPixels", 64'(expQ.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/vga_photo_reader.md
# vga_photo_reader

Upstream pixel source for `vga_driver` in the VGA photo design. Tracks the driver's HSYNC/VSYNC outputs to recover the current active-area scan position. For every position inside a 128x96 image window it fetches the pixel from a synchronous image ROM. It presents each pixel together with its screen coordinates, so the driver's coordinate match latches it into the frame.

## Interface
Parameters:
- `X_SIZE`, 128: image width in pixels.
- `Y_SIZE`, 96: image height in lines.
- `H_OFS`, 88: clocks from an HSYNC rising edge to active column 0.
- `V_OFS`, 23: HSYNC rising edges from a VSYNC rising edge to active line 0.
- `ORG_X0`, 0: window origin column (initial value when bouncing).
- `ORG_Y0`, 0: window origin line (initial value when bouncing).

Ports (one clock; reset is synchronous and active-high):
- `CLK_40M` in 1: pixel clock.
- `RST` in 1: synchronous active-high reset.
- `HSYNC` in 1: from `vga_driver`, active-low pulse.
- `VSYNC` in 1: from `vga_driver`, active-low pulse.
- `ROM_DATA` in 8: image ROM read data, valid one clock after `ROM_ADDR`.
- `ROM_ADDR` out 14: image ROM address, range 0..X_SIZE*Y_SIZE-1.
- `VGA_X` out 16: screen column of `VGA_DATA`.
- `VGA_Y` out 16: screen line of `VGA_DATA`.
- `VGA_DATA` out 8: pixel value.
- `VGA_VALID` out 1: `VGA_X`, `VGA_Y` and `VGA_DATA` carry a window pixel.

## Operation
- Edge detection: HSYNC and VSYNC are each registered once. A rising edge is previous 0 / current 1.
- Line counter `lcnt` (10 bit):
  - cleared on a VSYNC rise.
  - incremented on each HSYNC rise.
  - saturates at 1023.
- Column counter `ccnt` (11 bit):
  - cleared on an HSYNC rise.
  - otherwise incremented each clock.
  - saturates at 2047.
- Active position: row = lcnt - V_OFS, col = ccnt - H_OFS. Position is only valid when lcnt ≥ V_OFS and ccnt ≥ H_OFS.
- In-window condition: ORG_X ≤ col < ORG_X+X_SIZE and ORG_Y ≤ row < ORG_Y+Y_SIZE.
- State machine:
  - `WAIT_FRAME` (reset state). On a VSYNC rise, go to `ABOVE`.
  - `ABOVE`. When row == ORG_Y is reached at an HSYNC rise, go to `SCAN`.
  - `SCAN`. Fetch pixels. When row == ORG_Y+Y_SIZE is reached at an HSYNC rise, go to `BELOW`.
  - `BELOW`. On a VSYNC rise, go to `ABOVE`.
  - From any state, a VSYNC rise forces `ABOVE` and clears the address counter.
- Address counter:
  - increments by 1 on every in-window clock in `SCAN`.
  - reset to 0 on a VSYNC rise.
  - never exceeds X_SIZE*Y_SIZE-1; at 12287 it holds.
- Reset mid-frame: the next clock gives state `WAIT_FRAME`, all outputs 0, and counters 0. No pixel is emitted until the first VSYNC rise after reset is released.
- A VSYNC rise and an HSYNC rise in the same clock: the VSYNC action (lcnt cleared) takes precedence, and the HSYNC rise is not counted.

## Timing
- Reset values: `ROM_ADDR`, `VGA_X`, `VGA_Y`, `VGA_DATA` and `VGA_VALID` are all 0. Origin resets to ORG_X0/ORG_Y0.
- Pipeline:
  - stage 0 computes in-window and drives `ROM_ADDR` (registered).
  - stage 1 receives ROM data.
  - stage 2 registers `VGA_DATA`, `VGA_X` and `VGA_Y` (delayed copies of col/row) and `VGA_VALID`.
- Latency: 2 clocks from the in-window position to the outputs. Every output is registered.
- `VGA_VALID` is high for exactly X_SIZE consecutive clocks per image line and Y_SIZE lines per frame. When it is low, the outputs hold their last values.

## Configuration
- `VGA_PHOTO_BOUNCE_EN` defined: the origin moves diagonally by ±1 per frame.
  - The update is made on the VSYNC rise, before the address clear.
  - The X direction reverses when ORG_X reaches 0 or 800-X_SIZE. The Y direction reverses at 0 or 600-Y_SIZE.
  - A reversal takes effect on the same frame step. Example: ORG_X=672, dx=+1 gives ORG_X=671, dx=-1.
  - The initial direction is dx=+1, dy=+1.
- `VGA_PHOTO_BOUNCE_EN` undefined: the origin is constant ORG_X0/ORG_Y0 and no direction registers exist.

## Structure
- Package `vga_photo_pkg` holds:
  - the timing constants (800/600 active, H_OFS/V_OFS defaults).
  - the X_SIZE/Y_SIZE defaults.
  - the ROM address width.
  - the state enum `{WAIT_FRAME, ABOVE, SCAN, BELOW}`.
- Sub-module `vga_sync_edge`: one register plus rising-edge detect. It is instantiated twice, once for HSYNC and once for VSYNC.

## Test plan
- Reset release with sync low: outputs stay at 0 and `VGA_VALID` stays 0 until the first VSYNC rise.
- ORG=(0,0), full 1056x628 timing, ROM data = addr[7:0]:
  - The first valid pixel appears 2 clocks after ccnt=88 on line lcnt=23, with X=0, Y=0, DATA=0x00.
  - Pixel X=127, Y=95 has DATA=(12287 & 0xFF)=0xFF.
- Valid count: across one frame `VGA_VALID` is high for exactly 12288 clocks, and `ROM_ADDR` ends at 12287.
- ORG=(600,500): the first valid pixel has X=600, Y=500. No valid pixel has X≥728 or Y≥596.
- RST asserted for 1 clock at row 40 of the window: the next clock gives all outputs 0. The next frame restarts at DATA for address 0.
- With `VGA_PHOTO_BOUNCE_EN`, start at ORG_X0=671, ORG_Y0=0. After 3 VSYNC rises, expect ORG_X: 672, 671, 670 and ORG_Y: 1, 2, 3.
